// File: rtl/asrm_bus_initiator_if.sv
// Command, response and system-bus signals of the bus initiator.
// master: the initiator (takes commands, drives the bus).
// slave : the command source plus the peripheral.
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : command handshake
//   rsp_valid/rsp_data                           : one-cycle response
//   bus_addr/bus_write_en/bus_wdata/bus_rdata    : peripheral bus
interface asrm_bus_initiator_if #(
  parameter int wordsize  = 16,
  parameter int addr_size = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [addr_size-1:0] cmd_addr;
  logic [wordsize-1:0]  cmd_data;
  logic                 rsp_valid;
  logic [wordsize-1:0]  rsp_data;
  logic [addr_size-1:0] bus_addr;
  logic                 bus_write_en;
  logic [wordsize-1:0]  bus_wdata;
  logic [wordsize-1:0]  bus_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, bus_rdata,
    output cmd_ready, rsp_valid, rsp_data, bus_addr, bus_write_en, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_data, bus_addr, bus_write_en, bus_wdata
  );
endinterface

// File: rtl/asrm_bus_initiator.sv
// Bus initiator: turns READ / WRITE / SET / CLEAR / TOGGLE commands into
// single-cycle system-bus accesses to a peripheral with one cycle of read
// latency, performing read-modify-write for the bit operations.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   port  : master side of asrm_bus_initiator_if (command, response, bus)
// Timing: the state register runs one cycle ahead of the registered bus
// and response outputs, i.e. the outputs for a phase are computed while
// the FSM is in that phase and become visible in the following cycle.
// This gives accept->rsp_valid latencies of 2 (WRITE), 3 (READ) and
// 4 (SET/CLEAR/TOGGLE) cycles.
module asrm_bus_initiator #(
  parameter int wordsize  = 16,
  parameter int addr_size = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  asrm_bus_initiator_if.master  port
);

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_SAMPLE = 3'd2,
    S_WBACK  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [2:0]           op_q;
  logic [addr_size-1:0] addr_q;
  logic [wordsize-1:0]  data_q;

  logic [addr_size-1:0] bus_addr_q, bus_addr_d;
  logic                 bus_we_q, bus_we_d;
  logic [wordsize-1:0]  bus_wdata_q, bus_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [wordsize-1:0]  rsp_data_q, rsp_data_d;

  logic                 accept;
  logic                 is_write;
  logic                 is_rmw;
  logic [wordsize-1:0]  rmw_val;

  // ready_q keeps cmd_ready low until the first edge after reset release.
  assign port.cmd_ready = ready_q && (state_q == S_IDLE);
  assign accept         = port.cmd_valid && port.cmd_ready;

  // Reserved opcodes fall into neither class and therefore run as READ.
  assign is_write = (op_q == OP_WRITE);
  assign is_rmw   = (op_q == OP_SET) || (op_q == OP_CLEAR) || (op_q == OP_TOGGLE);

  // bus_rdata here is the peripheral's answer to the address driven one
  // cycle earlier, so it is consumed directly into the write-back register.
  always_comb begin
    rmw_val = port.bus_rdata;
    case (op_q)
      OP_SET:    rmw_val = port.bus_rdata | data_q;
      OP_CLEAR:  rmw_val = port.bus_rdata & ~data_q;
      OP_TOGGLE: rmw_val = port.bus_rdata ^ data_q;
      default:   rmw_val = port.bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_addr_d  = '0;
    bus_we_d    = 1'b0;
    bus_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus_addr_d = addr_q;
        if (is_write) begin
          bus_we_d    = 1'b1;
          bus_wdata_d = data_q;
          state_d     = S_RESP;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        bus_addr_d = addr_q;
        state_d    = is_rmw ? S_WBACK : S_RESP;
      end
      S_WBACK: begin
        bus_addr_d  = addr_q;
        bus_we_d    = 1'b1;
        bus_wdata_d = rmw_val;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (is_write) begin
          rsp_data_d = data_q;
        end else if (is_rmw) begin
          // The write-back value is still held on bus_wdata_q.
          rsp_data_d = bus_wdata_q;
        end else begin
          rsp_data_d = port.bus_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      if (accept) begin
        op_q   <= port.cmd_op;
        addr_q <= port.cmd_addr;
        data_q <= port.cmd_data;
      end
    end
  end

  assign port.bus_addr     = bus_addr_q;
  assign port.bus_write_en = bus_we_q;
  assign port.bus_wdata    = bus_wdata_q;
  assign port.rsp_valid    = rsp_valid_q;
  assign port.rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_asrm_bus_initiator.sv
// Bench for asrm_bus_initiator: a peripheral register file with a one-cycle
// registered read, a transaction-level reference model, a per-cycle compare
// process, directed scenarios and a randomized command stream.
module tb_asrm_bus_initiator;

  logic clk;
  logic reset;

  asrm_bus_initiator_if #(.wordsize(16), .addr_size(4)) bif ();

  asrm_bus_initiator #(.wordsize(16), .addr_size(4)) dut (
    .clk   (clk),
    .reset (reset),
    .port  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- peripheral: register file, registered read ----------
  logic [15:0] pmem [16];
  logic [15:0] rdata_q;

  always @(posedge clk) begin
    if (bif.bus_write_en) pmem[bif.bus_addr] <= bif.bus_wdata;
    rdata_q <= pmem[bif.bus_addr];
  end
  assign bif.bus_rdata = rdata_q;

  function automatic logic [15:0] init_val(input int i);
    if (i == 3) return 16'hABCD;
    if (i == 2) return 16'h0000;
    return 16'(i * 16'h1111);
  endfunction

  // ---------------- reference model ----------------
  // Each accepted command is described by its latency L, whether it writes,
  // which cycle after accept carries the write, and its result. Cycle j after
  // the accept edge: address visible for 1<=j<L, response at j==L.
  logic [15:0] shadow [16];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          mj;
  int          cj;
  bit          have_txn = 0;
  bit          ready_m = 0;
  int          m_lat;
  int          m_wj;
  bit          m_has_wr;
  logic [3:0]  m_addr;
  logic [15:0] m_res;
  logic [15:0] m_old;
  logic [15:0] rsp_hold = 0;
  logic [15:0] rsp_prev = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_txn = 0;
      ready_m  = 0;
      rsp_hold = 0;
      rsp_prev = 0;
    end else begin
      mj = cyc - acc_cyc;
      if (have_txn && m_has_wr && mj == m_wj) shadow[m_addr] = m_res;
      cyc = cyc + 1;
      if (bif.cmd_valid && ready_m && (!have_txn || mj >= m_lat)) begin
        m_addr = bif.cmd_addr;
        m_old  = shadow[m_addr];
        case (bif.cmd_op)
          3'd1: begin m_lat = 2; m_has_wr = 1; m_wj = 1; m_res = bif.cmd_data; end
          3'd2: begin m_lat = 4; m_has_wr = 1; m_wj = 3; m_res = m_old | bif.cmd_data; end
          3'd3: begin m_lat = 4; m_has_wr = 1; m_wj = 3; m_res = m_old & ~bif.cmd_data; end
          3'd4: begin m_lat = 4; m_has_wr = 1; m_wj = 3; m_res = m_old ^ bif.cmd_data; end
          default: begin m_lat = 3; m_has_wr = 0; m_wj = 0; m_res = m_old; end
        endcase
        rsp_prev = rsp_hold;
        rsp_hold = m_res;
        acc_cyc  = cyc;
        have_txn = 1;
      end
      ready_m = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0]  e_addr;
  logic        e_we, e_rv, e_rdy;
  logic [15:0] e_wd, e_rd;

  always @(negedge clk) begin
    if (!reset) begin
      e_addr = 0; e_we = 0; e_wd = 0; e_rv = 0; e_rd = 0; e_rdy = 0;
    end else begin
      cj = cyc - acc_cyc;
      e_addr = 0; e_we = 0; e_wd = 0; e_rv = 0; e_rd = rsp_hold; e_rdy = ready_m;
      if (have_txn && cj <= m_lat) begin
        if (cj >= 1 && cj < m_lat) e_addr = m_addr;
        if (m_has_wr && cj == m_wj) begin e_we = 1; e_wd = m_res; end
        e_rv  = (cj == m_lat);
        e_rd  = (cj == m_lat) ? rsp_hold : rsp_prev;
        e_rdy = ready_m && (cj == m_lat);
      end
    end
    chk("cyc_bus_addr",  32'(bif.bus_addr),     32'(e_addr));
    chk("cyc_write_en",  32'(bif.bus_write_en), 32'(e_we));
    chk("cyc_wdata",     32'(bif.bus_wdata),    32'(e_wd));
    chk("cyc_rsp_valid", 32'(bif.rsp_valid),    32'(e_rv));
    chk("cyc_rsp_data",  32'(bif.rsp_data),     32'(e_rd));
    chk("cyc_cmd_ready", 32'(bif.cmd_ready),    32'(e_rdy));
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!bif.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bif.cmd_ready;
    if (!ok) chk("ready_timeout", 32'(bif.cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bif.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [15:0] data,
                        input bit lit, input logic [15:0] exp_rsp, input int exp_lat);
    bit ok;
    int lat;
    wait_ready(ok);
    if (!ok) return;
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_addr  = addr;
    bif.cmd_data  = data;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    wait_rsp(lat);
    $display("txn op=%0d addr=%0h data=%04h rsp=%04h lat=%0d", op, addr, data, bif.rsp_data, lat);
    if (lit) begin
      chk("lit_latency", 32'(lat), 32'(exp_lat));
      chk("lit_rsp_data", 32'(bif.rsp_data), 32'(exp_rsp));
    end else begin
      chk("rsp_seen", 32'(lat != 0), 32'd1);
    end
  endtask

  initial begin
    bit ok;
    int n;
    int lat;
    for (int i = 0; i < 16; i++) begin
      pmem[i]   <= init_val(i);
      shadow[i] = init_val(i);
    end
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 3'd0;
    bif.cmd_addr  = 4'd0;
    bif.cmd_data  = 16'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_write_en",  32'(bif.bus_write_en), 32'd0);
    chk("reset_rsp_valid", 32'(bif.rsp_valid),    32'd0);
    chk("reset_rsp_data",  32'(bif.rsp_data),     32'd0);
    chk("reset_cmd_ready", 32'(bif.cmd_ready),    32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("ready_before_edge", 32'(bif.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_first_edge", 32'(bif.cmd_ready), 32'd1);

    // Directed register sequence.
    do_cmd(3'd1, 4'd2, 16'h0007, 1, 16'h0007, 2);
    do_cmd(3'd0, 4'd3, 16'h0000, 1, 16'hABCD, 3);
    do_cmd(3'd2, 4'd2, 16'h00F0, 1, 16'h00F7, 4);
    do_cmd(3'd3, 4'd2, 16'h0003, 1, 16'h00F4, 4);
    do_cmd(3'd4, 4'd2, 16'hFFFF, 1, 16'hFF0B, 4);
    do_cmd(3'd2, 4'd2, 16'h0000, 1, 16'hFF0B, 4);
    do_cmd(3'd6, 4'd5, 16'hFFFF, 1, 16'h5555, 3);

    // cmd_valid held high with a changing address during a READ.
    wait_ready(ok);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd0;
    bif.cmd_addr  = 4'd3;
    @(posedge clk); #1;
    bif.cmd_addr = 4'd4;
    n = 0;
    while (!bif.cmd_ready && n < 10) begin
      @(posedge clk); #1;
      bif.cmd_data = 16'($urandom);
      n++;
    end
    chk("held_ready_gap", 32'(n), 32'd3);
    chk("held_first_rsp", 32'(bif.rsp_data), 32'hABCD);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    wait_rsp(lat);
    $display("txn held second addr=4 rsp=%04h lat=%0d", bif.rsp_data, lat);
    chk("held_second_lat", 32'(lat), 32'd3);
    chk("held_second_rsp", 32'(bif.rsp_data), 32'h4444);

    // Reset during write-back of a SET.
    wait_ready(ok);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = 3'd2;
    bif.cmd_addr  = 4'd2;
    bif.cmd_data  = 16'h00F0;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("wback_write_en", 32'(bif.bus_write_en), 32'd1);
    chk("wback_wdata",    32'(bif.bus_wdata),    32'hFFFB);
    reset = 1'b0;
    #1;
    chk("abort_write_en",  32'(bif.bus_write_en), 32'd0);
    chk("abort_bus_addr",  32'(bif.bus_addr),     32'd0);
    chk("abort_rsp_valid", 32'(bif.rsp_valid),    32'd0);
    chk("abort_rsp_data",  32'(bif.rsp_data),     32'd0);
    chk("abort_cmd_ready", 32'(bif.cmd_ready),    32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_reg_kept", 32'(pmem[2]), 32'hFF0B);
    $display("txn aborted SET addr=2 reg=%04h", pmem[2]);

    // Randomized command stream.
    for (int i = 0; i < 60; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom), 0, 16'd0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asrm_bus_initiator.md
ASRM_BUS_INITIATOR -- requirements
Module: asrm_bus_initiator

Interface
REQ-001 Parameter: wordsize, default 16, data width of the system bus and the command port.
REQ-002 Parameter: addr_size, default 4, address width of the system bus.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: cmd_valid  input  1  command request.
REQ-006 Port: cmd_ready  output  1  block can accept a command.
REQ-007 Port: cmd_op  input  3  operation: 0 READ, 1 WRITE, 2 SET, 3 CLEAR, 4 TOGGLE, 5-7 reserved.
REQ-008 Port: cmd_addr  input  addr_size  target register address.
REQ-009 Port: cmd_data  input  wordsize  write data or bit mask.
REQ-010 Port: rsp_valid  output  1  one-cycle response pulse.
REQ-011 Port: rsp_data  output  wordsize  read value, or value written.
REQ-012 Port: bus_addr  output  addr_size  system bus address.
REQ-013 Port: bus_write_en  output  1  system bus write strobe.
REQ-014 Port: bus_wdata  output  wordsize  data to the peripheral's data_in.
REQ-015 Port: bus_rdata  input  wordsize  data from the peripheral's data_out.

Function
REQ-016 Handshake: a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; op, addr and data are latched at that edge.
REQ-017 cmd_ready SHALL be 1 only in IDLE; cmd_valid while busy is ignored and does not alter the transaction in progress.
REQ-018 FSM states SHALL be IDLE, ADDR, SAMPLE, WBACK, RESP; all bus and response outputs are registered.
REQ-019 IDLE outputs: bus_addr=0, bus_write_en=0, bus_wdata=0, rsp_valid=0; rsp_data holds its last value.
REQ-020 WRITE: IDLE->ADDR->RESP; in ADDR, bus_addr=addr, bus_wdata=data and bus_write_en=1 for exactly one cycle; rsp_data=data.
REQ-021 READ: IDLE->ADDR->SAMPLE->RESP; bus_write_en=0 throughout; bus_addr=addr in ADDR and SAMPLE; bus_rdata is captured at the end of SAMPLE (peripheral read latency of one cycle); rsp_data=captured value.
REQ-022 SET/CLEAR/TOGGLE: IDLE->ADDR->SAMPLE->WBACK->RESP; in WBACK, bus_write_en=1 for one cycle with bus_wdata = rd|mask, rd&~mask, or rd^mask respectively; rsp_data=written value.
REQ-023 Reserved ops 5-7 SHALL execute as READ; no bus write occurs.
REQ-024 RESP: rsp_valid=1 for exactly one cycle; next state IDLE unconditionally.
REQ-025 Latency from accept edge to rsp_valid high: WRITE 2 cycles, READ 3, RMW 4; minimum spacing between accepts is latency+1 cycles.
REQ-026 bus_write_en SHALL never be asserted for more than one consecutive cycle per command, and never in IDLE, SAMPLE or RESP.
REQ-027 Bitwise operations SHALL be full wordsize width, with no carry; mask=0 writes back the read value unchanged.
REQ-028 cmd_addr SHALL be used unmodified; address decode belongs to the peripheral.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, bus_addr=0, bus_write_en=0, bus_wdata=0, rsp_valid=0, rsp_data=0 and cmd_ready=0, without waiting for clk.
REQ-030 While reset=0, cmd_ready SHALL be 0; after release, cmd_ready=1 from the first rising edge.
REQ-031 Reset asserted mid-transaction SHALL abort it, with no further bus write and no response pulse.

Verification
REQ-032 Bench scenarios use a behavioural register model with a one-cycle registered read:
- WRITE addr 2, data 0x0007 -> bus_write_en high for one cycle with addr 2 and wdata 0x0007; rsp_valid 2 cycles after accept, rsp_data 0x0007.
- READ addr 3, model holds 0xABCD -> no write strobe; rsp_valid 3 cycles after accept, rsp_data 0xABCD.
- SET addr 2 mask 0x00F0 on 0x0007 -> write 0x00F7; CLEAR mask 0x0003 -> 0x00F4; TOGGLE mask 0xFFFF -> 0xFF0B; each rsp_valid at 4 cycles.
- cmd_valid held high with changing cmd_addr during a READ -> only the first command executes; the second is accepted in the IDLE cycle after RESP.
- reset pulled low in WBACK of a SET -> bus_write_en drops asynchronously, no rsp_valid, model register unchanged.
- Op 6 on addr 5 -> behaves as READ; bus_write_en never asserts.
